// File: rtl/ysyx22040413_ifu_pkg.sv
// Shared definitions for the instruction fetch unit: widths, reset PC and
// the fetch state encoding used by the request/response sequencer.
package ysyx22040413_ifu_pkg;

    // Address/PC width of the core (same value as the core-wide register bus).
    localparam int REG_BUS = 64;

    // Instruction word width.
    localparam int INST_W = 32;

    // PC loaded into the fetch unit when reset is applied.
    localparam logic [REG_BUS-1:0] PC_RESET = 64'h0000_0000_8000_0000;

    // Instruction bus type.
    typedef logic [INST_W-1:0] inst_bus_t;

    // REQ:  allowed to issue a request.
    // WAIT: one request outstanding, its response will be buffered.
    // DROP: one request outstanding, its response belongs to a flushed path.
    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2
    } ifu_state_e;

endpackage

// File: rtl/ysyx22040413_fetch_buf.sv
// Small synchronous FIFO of fetched {inst, pc} pairs. The head entry is kept
// in dedicated registers so the decode stage sees registered outputs, and
// the head holds its last value whenever the FIFO is empty.
module ysyx22040413_fetch_buf
    import ysyx22040413_ifu_pkg::*;
#(
    parameter int XLEN  = REG_BUS,
    parameter int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [INST_W-1:0] push_inst,
    input  logic [XLEN-1:0]   push_pc,
    input  logic              pop,
    input  logic              flush,
    output logic [CNT_W-1:0]  count,
    output logic [INST_W-1:0] head_inst,
    output logic [XLEN-1:0]   head_pc
);

    logic [INST_W-1:0] inst_mem [DEPTH];
    logic [XLEN-1:0]   pc_mem   [DEPTH];

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  rd_ptr_next;
    logic [CNT_W-1:0]  count_next;
    logic              do_push;
    logic              do_pop;
    logic              head_from_push;
    logic [INST_W-1:0] head_inst_next;
    logic [XLEN-1:0]   head_pc_next;

    // Qualify push/pop (flush wins over both) and work out what the head
    // registers must show after this edge; when the new head is the entry
    // being written right now it is taken straight from the push data.
    always_comb begin
        do_push        = push && !flush && (count < CNT_W'(DEPTH));
        do_pop         = pop && !flush && (count != '0);
        rd_ptr_next    = do_pop ? rd_ptr + PTR_W'(1) : rd_ptr;
        count_next     = count + CNT_W'(do_push) - CNT_W'(do_pop);
        head_from_push = do_push && (rd_ptr_next == wr_ptr);
        head_inst_next = head_inst;
        head_pc_next   = head_pc;
        if (!flush && (count_next != '0)) begin
            if (head_from_push) begin
                head_inst_next = push_inst;
                head_pc_next   = push_pc;
            end else begin
                head_inst_next = inst_mem[rd_ptr_next];
                head_pc_next   = pc_mem[rd_ptr_next];
            end
        end
    end

    // Pointer, occupancy and head registers; a flush empties the FIFO but
    // leaves the head registers at their last value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            head_inst <= '0;
            head_pc   <= '0;
        end else begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (do_push) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                rd_ptr <= rd_ptr_next;
                count  <= count_next;
            end
            head_inst <= head_inst_next;
            head_pc   <= head_pc_next;
        end
    end

    // Storage array; contents are only meaningful below the occupancy count,
    // so it needs no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            inst_mem[wr_ptr] <= push_inst;
            pc_mem[wr_ptr]   <= push_pc;
        end
    end

endmodule

// File: rtl/ysyx22040413_ifu.sv
// Instruction fetch unit: owns the PC, issues one 32-bit fetch at a time to
// instruction memory, buffers the returned words and hands {inst, pc} to
// decode. A redirect from execute flushes everything fetched on the old path.
module ysyx22040413_ifu #(
    parameter int               XLEN      = 64,
    parameter logic [XLEN-1:0]  PC_RESET  = 64'h0000_0000_8000_0000,
    parameter int               BUF_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [31:0]     imem_resp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [31:0]     inst,
    output logic [XLEN-1:0] inst_pc
);

    import ysyx22040413_ifu_pkg::*;

    localparam int CNT_W = $clog2(BUF_DEPTH) + 1;

    ifu_state_e       state;
    ifu_state_e       state_next;
    logic [XLEN-1:0]  fetch_pc;
    logic [XLEN-1:0]  fetch_pc_next;
    logic [XLEN-1:0]  req_pc;
    logic [XLEN-1:0]  req_pc_next;
    logic             req_fire;
    logic             buf_push;
    logic             buf_pop;
    logic [CNT_W-1:0] buf_count;

    // A request is only offered when the buffer has room for its response,
    // which is what keeps the FIFO from ever overflowing.
    assign imem_req_valid = (state == ST_REQ) && (buf_count < CNT_W'(BUF_DEPTH)) && !rst;
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign inst_valid     = (buf_count != '0);
    assign buf_pop        = inst_valid && inst_ready;

    // State, fetch PC and the PC of the outstanding request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_REQ;
            fetch_pc <= PC_RESET;
            req_pc   <= PC_RESET;
        end else begin
            state    <= state_next;
            fetch_pc <= fetch_pc_next;
            req_pc   <= req_pc_next;
        end
    end

    // Fetch sequencing; a redirect overrides normal progress and decides
    // whether a request is still in flight that must have its data dropped.
    always_comb begin
        state_next    = state;
        fetch_pc_next = fetch_pc;
        req_pc_next   = req_pc;
        buf_push      = 1'b0;
        if (redirect_valid) begin
            fetch_pc_next = {redirect_pc[XLEN-1:2], 2'b00};
            case (state)
                ST_WAIT, ST_DROP: state_next = imem_resp_valid ? ST_REQ : ST_DROP;
                default:          state_next = req_fire ? ST_DROP : ST_REQ;
            endcase
        end else begin
            case (state)
                ST_REQ: begin
                    if (req_fire) begin
                        req_pc_next   = fetch_pc;
                        fetch_pc_next = fetch_pc + XLEN'(4);
                        state_next    = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (imem_resp_valid) begin
                        buf_push   = 1'b1;
                        state_next = ST_REQ;
                    end
                end
                ST_DROP: begin
                    if (imem_resp_valid) begin
                        state_next = ST_REQ;
                    end
                end
                default: state_next = ST_REQ;
            endcase
        end
    end

    ysyx22040413_fetch_buf #(
        .XLEN  (XLEN),
        .DEPTH (BUF_DEPTH)
    ) u_fetch_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (buf_push),
        .push_inst (imem_resp_data),
        .push_pc   (req_pc),
        .pop       (buf_pop),
        .flush     (redirect_valid),
        .count     (buf_count),
        .head_inst (inst),
        .head_pc   (inst_pc)
    );

endmodule

// File: tb/tb_ysyx22040413_ifu.sv
// Bench for the fetch unit: a memory model answering requests, a scoreboard
// holding the instruction stream decode should see, and directed plus
// random stimulus around it.
module tb_ysyx22040413_ifu;

    localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;

    typedef struct packed {
        logic [31:0] inst;
        logic [63:0] pc;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [63:0] inst_pc;

    exp_t        exp_q[$];
    logic [63:0] req_log[$];
    int          errors = 0;
    int          checks = 0;
    int          delivered = 0;
    int          mem_ready_pct = 100;
    int          mem_delay_min = 0;
    int          mem_delay_max = 0;

    ysyx22040413_ifu dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst            (inst),
        .inst_pc         (inst_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Contents of instruction memory: a distinct word for every address.
    function automatic logic [31:0] mem_data(input logic [63:0] a);
        return (a[31:0] * 32'h9E37_79B1) ^ a[63:32];
    endfunction

    // Decode must see the words at start, start+4, ... until the next redirect.
    function automatic void refill(input logic [63:0] start);
        logic [63:0] pc;
        exp_t        e;
        pc = start & ~64'd3;
        exp_q.delete();
        for (int i = 0; i < 256; i++) begin
            e.pc   = pc;
            e.inst = mem_data(pc);
            exp_q.push_back(e);
            pc = pc + 64'd4;
        end
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
        end
    endtask

    task automatic checkReq(input string name, input int idx, input logic [63:0] expected);
        if (idx >= req_log.size()) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s: only %0d requests seen, required 0x%0h at index %0d",
                     name, req_log.size(), expected, idx);
        end else begin
            checkOutput(name, req_log[idx], expected);
        end
    endtask

    task automatic applyStimulus(input logic ir, input logic rv, input logic [63:0] rp);
        @(negedge clk);
        inst_ready     = ir;
        redirect_valid = rv;
        redirect_pc    = rp;
        #1;
    endtask

    task automatic applyReset();
        @(negedge clk);
        rst            = 1'b1;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        refill(RESET_PC);
        @(negedge clk);
        @(negedge clk);
        req_log.delete();
        rst = 1'b0;
        #1;
    endtask

    // Memory model: random acceptance, one response 1+ cycles after each
    // accepted request, and checks on request stability and outstanding count.
    initial begin : memory_model
        logic        outstanding;
        int          resp_cnt;
        logic [63:0] out_addr;
        logic        prev_hold;
        logic [63:0] prev_addr;
        outstanding     = 1'b0;
        resp_cnt        = 0;
        out_addr        = '0;
        prev_hold       = 1'b0;
        prev_addr       = '0;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        forever begin
            @(negedge clk);
            imem_resp_valid = 1'b0;
            if (rst) begin
                outstanding = 1'b0;
            end else if (outstanding) begin
                if (resp_cnt == 0) begin
                    imem_resp_valid = 1'b1;
                    imem_resp_data  = mem_data(out_addr);
                    outstanding     = 1'b0;
                end else begin
                    resp_cnt--;
                end
            end
            imem_req_ready = ($urandom_range(99) < mem_ready_pct);
            #2;
            if (rst) begin
                prev_hold = 1'b0;
            end else begin
                if (prev_hold) begin
                    checkOutput("req_hold_valid", 64'(imem_req_valid), 64'd1);
                    checkOutput("req_hold_addr", imem_req_addr, prev_addr);
                end
                if (imem_req_valid && imem_req_ready) begin
                    checkOutput("one_outstanding", 64'(outstanding), 64'd0);
                    checkOutput("req_addr_align", 64'(imem_req_addr[1:0]), 64'd0);
                    outstanding = 1'b1;
                    out_addr    = imem_req_addr;
                    resp_cnt    = $urandom_range(mem_delay_max, mem_delay_min);
                    req_log.push_back(imem_req_addr);
                end
                prev_hold = imem_req_valid && !imem_req_ready && !redirect_valid;
                prev_addr = imem_req_addr;
            end
        end
    end

    // Monitor: every instruction taken by decode is compared with the
    // scoreboard; a redirect restarts the required stream.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst) begin
                if (redirect_valid) begin
                    refill(redirect_pc);
                end else if (inst_valid && inst_ready) begin
                    delivered++;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL scoreboard: got inst_pc 0x%0h, none required", inst_pc);
                    end else begin
                        e = exp_q.pop_front();
                        checkOutput("inst_pc", inst_pc, e.pc);
                        checkOutput("inst", 64'(inst), 64'(e.inst));
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete, errors=%0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : driver
        int  d0;
        logic found;
        rst            = 1'b0;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        refill(RESET_PC);
        #1 rst = 1'b1;
        #2;
        checkOutput("rst_req_valid", 64'(imem_req_valid), 64'd0);
        checkOutput("rst_req_addr", imem_req_addr, RESET_PC);
        checkOutput("rst_inst_valid", 64'(inst_valid), 64'd0);
        checkOutput("rst_inst", 64'(inst), 64'd0);
        checkOutput("rst_inst_pc", inst_pc, 64'd0);

        // Release with zero-wait memory and an always-ready decode stage.
        @(negedge clk);
        @(negedge clk);
        rst        = 1'b0;
        inst_ready = 1'b1;
        #1;
        checkOutput("release_req_valid", 64'(imem_req_valid), 64'd1);
        checkOutput("release_req_addr", imem_req_addr, RESET_PC);
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b0, '0);
        d0 = delivered;
        for (int i = 0; i < 20; i++) applyStimulus(1'b1, 1'b0, '0);
        checkOutput("throughput", 64'(delivered - d0), 64'd10);
        checkReq("seq_req0", 0, 64'h8000_0000);
        checkReq("seq_req1", 1, 64'h8000_0004);
        checkReq("seq_req2", 2, 64'h8000_0008);

        // Decode stalled: buffer fills with two entries and fetching stops.
        applyReset();
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, '0);
        checkOutput("full_inst_valid", 64'(inst_valid), 64'd1);
        checkOutput("full_req_valid", 64'(imem_req_valid), 64'd0);
        checkOutput("full_head_pc", inst_pc, 64'h8000_0000);
        checkOutput("full_head_inst", 64'(inst), 64'(mem_data(64'h8000_0000)));
        checkOutput("full_req_count", 64'(req_log.size()), 64'd2);
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0, '0);
        checkReq("resume_req", 2, 64'h8000_0008);

        // Memory not ready: request held stable, no PC advance.
        mem_ready_pct = 0;
        applyReset();
        inst_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checkOutput("stall_req_valid", 64'(imem_req_valid), 64'd1);
            checkOutput("stall_req_addr", imem_req_addr, 64'h8000_0000);
            applyStimulus(1'b1, 1'b0, '0);
        end
        checkOutput("stall_no_accept", 64'(req_log.size()), 64'd0);
        mem_ready_pct = 100;
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, '0);
        checkReq("stall_first_req", 0, 64'h8000_0000);

        // Redirect while waiting for a slow response.
        mem_delay_min = 3;
        mem_delay_max = 3;
        applyReset();
        applyStimulus(1'b1, 1'b1, 64'h8000_1002);
        applyStimulus(1'b1, 1'b0, '0);
        req_log.delete();
        for (int i = 0; i < 14; i++) applyStimulus(1'b1, 1'b0, '0);
        checkReq("redir_wait_req", 0, 64'h8000_1000);
        mem_delay_min = 2;
        mem_delay_max = 2;

        // Redirect in the same cycle as a response, with an entry buffered.
        applyReset();
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            applyStimulus(1'b0, 1'b0, '0);
            if (imem_resp_valid && inst_valid) found = 1'b1;
        end
        if (!found) begin
            checks++;
            errors++;
            $display("[TB] FAIL redir_resp_setup: got no response with buffered entry, required one within 30 cycles");
        end else begin
            d0             = delivered;
            inst_ready     = 1'b1;
            redirect_valid = 1'b1;
            redirect_pc    = 64'h8000_2000;
            applyStimulus(1'b1, 1'b0, '0);
            checkOutput("redir_resp_flushed", 64'(inst_valid), 64'd0);
            checkOutput("redir_resp_req_valid", 64'(imem_req_valid), 64'd1);
            checkOutput("redir_resp_req_addr", imem_req_addr, 64'h8000_2000);
            checkOutput("redir_resp_no_deliver", 64'(delivered - d0), 64'd0);
        end
        mem_delay_min = 0;
        mem_delay_max = 0;
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b0, '0);

        // Asynchronous reset while a request is outstanding and entries wait.
        applyReset();
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, '0);
        mem_delay_min = 5;
        mem_delay_max = 5;
        applyStimulus(1'b1, 1'b0, '0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, '0);
        checkOutput("pre_rst_req_valid", 64'(imem_req_valid), 64'd0);
        checkOutput("pre_rst_inst_valid", 64'(inst_valid), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_rst_inst_valid", 64'(inst_valid), 64'd0);
        checkOutput("async_rst_req_valid", 64'(imem_req_valid), 64'd0);
        checkOutput("async_rst_req_addr", imem_req_addr, RESET_PC);
        checkOutput("async_rst_inst_pc", inst_pc, 64'd0);
        refill(RESET_PC);
        mem_delay_min = 0;
        mem_delay_max = 0;
        @(negedge clk);
        @(negedge clk);
        req_log.delete();
        rst        = 1'b0;
        inst_ready = 1'b1;
        #1;
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b0, '0);
        checkReq("after_rst_req", 0, 64'h8000_0000);

        // PC wraps around the top of the address space.
        applyStimulus(1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
        applyStimulus(1'b1, 1'b0, '0);
        req_log.delete();
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0, '0);
        checkReq("wrap_req0", 0, 64'hFFFF_FFFF_FFFF_FFFC);
        checkReq("wrap_req1", 1, 64'h0000_0000_0000_0000);
        checkReq("wrap_req2", 2, 64'h0000_0000_0000_0004);

        // Random traffic: memory stalls/latency, decode back-pressure, redirects.
        mem_ready_pct = 70;
        mem_delay_min = 0;
        mem_delay_max = 3;
        for (int i = 0; i < 1500; i++) begin
            applyStimulus(($urandom_range(99) < 60), ($urandom_range(99) < 3),
                          {$urandom(), $urandom()});
        end
        applyStimulus(1'b1, 1'b0, '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
